// File: rtl/mips_pkg.sv
// Shared fetch-path definitions: widths, NOP encoding, fetch FSM states and
// the prefetch-buffer entry layout.
package mips_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned FB_DEPTH = 2;
  localparam int unsigned FB_CNT_W = 2;
  localparam int unsigned OCC_W    = FB_CNT_W + 1;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pcplus4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry prefetch FIFO of {instr, pc+4}.
// Ports:
//   clk, reset_n   clock, async active-low reset
//   clear          drop all entries (wins over push/pop)
//   push, wdata    enqueue one entry
//   pop            dequeue the head (ignored when empty)
//   count          occupancy 0..2
//   head           oldest entry (undefined when count = 0)
module fetch_buffer
  import mips_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                push,
  input  logic                pop,
  input  fetch_entry_t        wdata,
  output logic [FB_CNT_W-1:0] count,
  output fetch_entry_t        head
);

  fetch_entry_t        mem_q [FB_DEPTH];
  logic                rd_ptr_q;
  logic                wr_ptr_q;
  logic [FB_CNT_W-1:0] count_q;
  logic                do_push;
  logic                do_pop;

  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != FB_CNT_W'(FB_DEPTH)) || do_pop);

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else if (clear) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + FB_CNT_W'(1);
        2'b01:   count_q <= count_q - FB_CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents are meaningless until counted, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, runs a single-outstanding req/ack
// handshake to instruction memory, buffers up to two fetched words and
// presents the head to the fetch/decode register, with redirect squashing.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   StallD                decode not capturing this cycle (head held)
//   PCSrcD, PCBranchD     taken-branch redirect from decode (only when !StallD)
//   imem_req, imem_addr   fetch request and address (held until ack)
//   imem_ack, imem_rdata  memory response, data valid with ack
//   instrF, PcPlus4F      buffer head to decode, zero for a bubble
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            StallD,
  input  logic            PCSrcD,
  input  logic [XLEN-1:0] PCBranchD,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instrF,
  output logic [XLEN-1:0] PcPlus4F
);

  fetch_state_e        state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic                req_q, req_d;

  logic                redirect;
  logic                ack_req;
  logic                push;
  logic                pop;
  logic                room;
  logic [OCC_W-1:0]    occ_next;
  logic [FB_CNT_W-1:0] count;
  fetch_entry_t        head;
  fetch_entry_t        wentry;

  assign redirect = PCSrcD & ~StallD;
  // Acks while in DROP belong to a squashed request and are never accepted.
  assign ack_req  = (state_q == REQ) & imem_ack;
  assign push     = ack_req & ~redirect;
  assign pop      = ~StallD & (count != '0);

  // Occupancy after this cycle's push/pop decides whether a new request fits.
  assign occ_next = OCC_W'(count) + OCC_W'(push) - OCC_W'(pop);
  assign room     = occ_next < OCC_W'(FB_DEPTH);

  assign wentry.instr   = imem_rdata;
  assign wentry.pcplus4 = pc_q + PC_STEP;

  fetch_buffer u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (redirect),
    .push    (push),
    .pop     (pop),
    .wdata   (wentry),
    .count   (count),
    .head    (head)
  );

  // Next state, next PC and next request address.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (redirect || room) state_d = REQ;
      end
      REQ: begin
        if (redirect)      state_d = imem_ack ? REQ : DROP;
        else if (imem_ack) state_d = room ? REQ : IDLE;
      end
      DROP: begin
        // The stale request must complete before the redirected one is issued.
        if (imem_ack) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    if (ack_req)  pc_d = pc_q + PC_STEP;
    if (redirect) pc_d = PCBranchD;

    // DROP keeps presenting the abandoned address; otherwise track the PC.
    addr_d = (state_d == DROP) ? addr_q : pc_d;
    req_d  = (state_d != IDLE);
  end

  // FSM, PC and registered memory-side outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;

  // Head to decode; bubble when empty or when the head is being squashed.
  always_comb begin
    instrF   = NOP_INSTR;
    PcPlus4F = '0;
    if ((count != '0) && !redirect) begin
      instrF   = head.instr;
      PcPlus4F = head.pcplus4;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: variable-latency memory model, randomized
// stall/redirect driver, and a scoreboard of the expected program-order
// stream that decode should capture.
`timescale 1ns/1ps
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        StallD;
  logic        PCSrcD;
  logic [31:0] PCBranchD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instrF;
  logic [31:0] PcPlus4F;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .StallD     (StallD),
    .PCSrcD     (PCSrcD),
    .PCBranchD  (PCBranchD),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instrF     (instrF),
    .PcPlus4F   (PcPlus4F)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcp4;
  } exp_t;

  int   tests    = 0;
  int   fails    = 0;
  int   captures = 0;
  exp_t exp_q[$];
  int   lat_mode = 0;  // 0: zero-wait, 1: fixed 3 waits, 2: random 0..3 waits

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Program order from address a: what decode must see until the next redirect.
  task automatic restart(input logic [31:0] a);
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      e.instr = word_at(a + 32'(i) * 32'd4);
      e.pcp4  = a + 32'(i) * 32'd4 + 32'd4;
      exp_q.push_back(e);
    end
  endtask

  // Instruction memory: one request at a time, latency chosen at request start.
  logic        mem_busy = 1'b0;
  int          wait_left = 0;
  logic [31:0] held_addr = 32'h0;
  always @(negedge clk) begin
    if (!reset_n) begin
      imem_ack = 1'b0;
      mem_busy = 1'b0;
    end else if (imem_req) begin
      if (!mem_busy) begin
        mem_busy  = 1'b1;
        held_addr = imem_addr;
        case (lat_mode)
          0:       wait_left = 0;
          1:       wait_left = 3;
          default: wait_left = $urandom_range(0, 3);
        endcase
      end else begin
        check("addr_stable", imem_addr, held_addr);
      end
      if (wait_left == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = word_at(imem_addr);
        mem_busy   = 1'b0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        wait_left--;
      end
    end else begin
      if (mem_busy) check("req_held_until_ack", 32'(imem_req), 32'd1);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      mem_busy   = 1'b0;
    end
  end

  // Monitor: samples late in the cycle, pops the scoreboard on each capture.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_i = 32'h0;
  logic [31:0] prev_p = 32'h0;
  exp_t        mon_e;
  always @(negedge clk) begin
    #3;
    if (!reset_n) begin
      prev_hold = 1'b0;
    end else if (PCSrcD && !StallD) begin
      check("redirect_kill_instr", instrF, 32'h0);
      check("redirect_kill_pcp4", PcPlus4F, 32'h0);
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("stall_hold_instr", instrF, prev_i);
        check("stall_hold_pcp4", PcPlus4F, prev_p);
      end
      check("bubble_consistent", 32'(instrF == 32'h0), 32'(PcPlus4F == 32'h0));
      if (!StallD && (PcPlus4F != 32'h0)) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL capture_underflow: got %h with no expected entry", PcPlus4F);
        end else begin
          mon_e = exp_q.pop_front();
          check("capture_instr", instrF, mon_e.instr);
          check("capture_pcp4", PcPlus4F, mon_e.pcp4);
          captures++;
        end
      end
      prev_hold = StallD && (PcPlus4F != 32'h0);
      prev_i    = instrF;
      prev_p    = PcPlus4F;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Driver.
  initial begin
    int n;
    int since;
    reset_n   = 1'b0;
    StallD    = 1'b0;
    PCSrcD    = 1'b0;
    PCBranchD = 32'h0;
    lat_mode  = 0;
    restart(RESET_PC);
    repeat (3) tick();
    check("reset_req", 32'(imem_req), 32'd0);
    check("reset_addr", imem_addr, RESET_PC);
    check("reset_instr", instrF, 32'h0);
    check("reset_pcp4", PcPlus4F, 32'h0);

    // Zero-wait memory from reset: one bubble, then one word per cycle.
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, RESET_PC);
    check("first_bubble", instrF, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("zw_instr", instrF, word_at(RESET_PC + 32'(i) * 32'd4));
      check("zw_pcp4", PcPlus4F, RESET_PC + 32'(i) * 32'd4 + 32'd4);
    end

    // Long stall fills the buffer and stops requests.
    tick();
    StallD = 1'b1;
    repeat (6) tick();
    check("full_no_req", 32'(imem_req), 32'd0);
    check("full_head_valid", 32'(PcPlus4F != 32'h0), 32'd1);
    StallD = 1'b0;
    repeat (10) tick();

    // Redirect while a slow request is outstanding.
    lat_mode = 1;
    repeat (8) tick();
    n = 0;
    while (!(imem_req && !imem_ack) && n < 50) begin tick(); n++; end
    check("inflight_found", 32'(imem_req && !imem_ack), 32'd1);
    PCSrcD    = 1'b1;
    PCBranchD = 32'h0000_0100;
    restart(32'h0000_0100);
    tick();
    PCSrcD = 1'b0;
    n = 0;
    while (!(imem_req && imem_addr == 32'h0000_0100) && n < 20) begin tick(); n++; end
    check("redirect_new_addr", imem_addr, 32'h0000_0100);
    repeat (15) tick();

    // Redirect in the same cycle as an ack.
    lat_mode = 2;
    n = 0;
    while (!imem_ack && n < 50) begin tick(); n++; end
    check("ack_found", 32'(imem_ack), 32'd1);
    PCSrcD    = 1'b1;
    PCBranchD = 32'h0000_0200;
    restart(32'h0000_0200);
    tick();
    PCSrcD = 1'b0;
    check("ack_redirect_req", 32'(imem_req), 32'd1);
    check("ack_redirect_addr", imem_addr, 32'h0000_0200);
    repeat (10) tick();

    // Redirect while stalled is ignored; the stream must continue in order.
    StallD    = 1'b1;
    PCSrcD    = 1'b1;
    PCBranchD = 32'h0000_0300;
    repeat (4) tick();
    PCSrcD = 1'b0;
    StallD = 1'b0;
    repeat (10) tick();

    // Reset pulse mid-request.
    n = 0;
    while (!imem_req && n < 50) begin tick(); n++; end
    reset_n = 1'b0;
    #1;
    check("async_req_drop", 32'(imem_req), 32'd0);
    check("async_instr_zero", instrF, 32'h0);
    restart(RESET_PC);
    repeat (2) tick();
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_restart_req", 32'(imem_req), 32'd1);
    check("rst_restart_addr", imem_addr, RESET_PC);
    repeat (10) tick();

    // Randomized stalls, redirects and memory latency.
    since = 0;
    for (int c = 0; c < 1500; c++) begin
      tick();
      StallD = ($urandom_range(0, 99) < 30);
      if (!StallD && (since > 150 || $urandom_range(0, 99) < 4)) begin
        PCSrcD    = 1'b1;
        PCBranchD = 32'($urandom_range(0, 32'h3FFF));
        restart(PCBranchD);
        since = 0;
      end else begin
        PCSrcD    = StallD && ($urandom_range(0, 99) < 10);
        PCBranchD = $urandom;
        since++;
      end
    end
    StallD = 1'b0;
    PCSrcD = 1'b0;
    repeat (10) tick();
    check("enough_captures", 32'(captures > 200), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
